// File: rtl/sd_route_pkg.sv
// Shared types and constants for the sd_route SD card router.
// The optional bus-idle switch guard is enabled with the SD_ROUTE_GUARD_EN macro.
package sd_route_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } sd_route_state_e;

    localparam int SD_ROUTE_MAX_SLOTS = 4;

    // Width of the target select: target 0 is the physical socket, 1..slots are virtual cards.
    function automatic int sel_w(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/sd_act_timer.sv
// One activity flag: samples mosi/miso, edge-detects against a delayed copy and
// runs a saturating counter that clears on an edge while this target is selected.
module sd_act_timer #(
    parameter int ACT_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sel_me,
    input  logic mosi,
    input  logic miso,
    output logic act
);

    localparam int               CNT_W   = $clog2(ACT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACT_TIMEOUT);

    logic [1:0]       smp_q, smp_d;
    logic [1:0]       dly_q, dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle;

    always_comb begin
        smp_d  = {miso, mosi};
        dly_d  = smp_q;
        toggle = |(smp_q ^ dly_q);
        cnt_d  = cnt_q;
        if (sel_me && toggle) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q <= '0;
            dly_q <= '0;
            cnt_q <= CNT_MAX;
        end else begin
            smp_q <= smp_d;
            dly_q <= dly_d;
            cnt_q <= cnt_d;
        end
    end

    assign act = (cnt_q < CNT_MAX);

endmodule

// File: rtl/sd_route.sv
// SD card router: steers one SPI master to the physical socket or a virtual slot.
// Define SD_ROUTE_GUARD_EN to defer target switches until spi_ss is high (bus idle).
module sd_route
    import sd_route_pkg::*;
#(
    parameter int SLOTS       = 1,
    parameter int ACT_TIMEOUT = 1000000,
    parameter int RST_HOLD    = 10000000,
    parameter int SEL_W       = sel_w(SLOTS)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [SLOTS-1:0] img_mounted,
    input  logic [SLOTS-1:0] img_nz,
    input  logic             spi_ss,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    output logic             spi_miso,
    input  logic [SLOTS-1:0] vsd_miso,
    output logic [SLOTS-1:0] vsd_ss,
    input  logic             SD_MISO,
    output logic             SD_CS,
    output logic             SD_SCK,
    output logic             SD_MOSI,
    output logic [SEL_W-1:0] sel,
    output logic             sel_pending,
    output logic [SLOTS:0]   act,
    output logic             reset_img
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    if (SLOTS < 1 || SLOTS > SD_ROUTE_MAX_SLOTS) begin : g_bad_slots
        $error("sd_route: SLOTS must be within 1..4");
    end

    sd_route_state_e  state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] req_q, req_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             reset_img_q, reset_img_d;
    logic             req_vld;
    logic [SEL_W-1:0] req_new;
    logic             bus_idle;

`ifdef SD_ROUTE_GUARD_EN
    assign bus_idle = spi_ss;
`else
    assign bus_idle = 1'b1;
`endif

    // Walk from the highest slot down so the lowest requesting slot overrides.
    always_comb begin
        req_vld = 1'b0;
        req_new = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (img_mounted[i]) begin
                if (img_nz[i]) begin
                    req_vld = 1'b1;
                    req_new = SEL_W'(i + 1);
                end else if (sel_q == SEL_W'(i + 1) ||
                             (state_q == ST_PENDING && req_q == SEL_W'(i + 1))) begin
                    req_vld = 1'b1;
                    req_new = '0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    state_d = ST_PENDING;
                    req_d   = req_new;
                end
            end
            ST_PENDING: begin
                if (req_vld) begin
                    req_d = req_new;
                end else if (bus_idle) begin
                    sel_d   = req_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Retriggerable hold: any mount reloads; the flag drops once the count reads zero.
    always_comb begin
        hold_d      = hold_q;
        reset_img_d = reset_img_q;
        if (|img_mounted) begin
            hold_d      = HOLD_W'(RST_HOLD);
            reset_img_d = 1'b1;
        end else if (reset_img_q) begin
            if (hold_q == '0) begin
                reset_img_d = 1'b0;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            req_q       <= '0;
            hold_q      <= '0;
            reset_img_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            req_q       <= req_d;
            hold_q      <= hold_d;
            reset_img_q <= reset_img_d;
        end
    end

    always_comb begin
        vsd_ss   = '1;
        SD_CS    = 1'b1;
        spi_miso = SD_MISO;
        if (sel_q == '0) begin
            SD_CS = spi_ss;
        end
        for (int k = 0; k < SLOTS; k++) begin
            if (sel_q == SEL_W'(k + 1)) begin
                vsd_ss[k] = spi_ss;
                spi_miso  = vsd_miso[k];
            end
        end
    end

    assign SD_SCK      = spi_sck & ~SD_CS;
    assign SD_MOSI     = spi_mosi & ~SD_CS;
    assign sel         = sel_q;
    assign sel_pending = (state_q == ST_PENDING);
    assign reset_img   = reset_img_q;

    logic [SLOTS:0] tgt_miso;
    assign tgt_miso = {vsd_miso, SD_MISO};

    for (genvar t = 0; t <= SLOTS; t++) begin : g_act
        sd_act_timer #(
            .ACT_TIMEOUT(ACT_TIMEOUT)
        ) u_timer (
            .clk    (clk_sys),
            .rst    (reset),
            .sel_me (sel_q == SEL_W'(t)),
            .mosi   (spi_mosi),
            .miso   (tgt_miso[t]),
            .act    (act[t])
        );
    end

endmodule

// File: tb/tb_sd_route.sv
// Directed bench for sd_route: the driver queues expected output values per cycle,
// a negedge monitor pops and compares them.
module tb_sd_route;

    localparam int SLOTS       = 3;
    localparam int ACT_TIMEOUT = 20;
    localparam int RST_HOLD    = 100;
    localparam int SEL_W       = 2;

`ifdef SD_ROUTE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam int K_SEL  = 0;
    localparam int K_PEND = 1;
    localparam int K_RIMG = 2;
    localparam int K_ACT  = 3;
    localparam int K_CS   = 4;
    localparam int K_VSS  = 5;
    localparam int K_MISO = 6;
    localparam int K_SCK  = 7;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] exp;
    } chk_t;

    chk_t exp_q[$];
    chk_t mon_c;
    logic [7:0] mon_act;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic             clk_sys = 1'b0;
    logic             reset = 1'b1;
    logic [SLOTS-1:0] img_mounted = '0;
    logic [SLOTS-1:0] img_nz = '0;
    logic             spi_ss = 1'b1;
    logic             spi_sck = 1'b0;
    logic             spi_mosi = 1'b0;
    logic             spi_miso;
    logic [SLOTS-1:0] vsd_miso = '0;
    logic [SLOTS-1:0] vsd_ss;
    logic             SD_MISO = 1'b0;
    logic             SD_CS;
    logic             SD_SCK;
    logic             SD_MOSI;
    logic [SEL_W-1:0] sel;
    logic             sel_pending;
    logic [SLOTS:0]   act;
    logic             reset_img;

    sd_route #(
        .SLOTS      (SLOTS),
        .ACT_TIMEOUT(ACT_TIMEOUT),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .img_mounted(img_mounted),
        .img_nz     (img_nz),
        .spi_ss     (spi_ss),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .vsd_miso   (vsd_miso),
        .vsd_ss     (vsd_ss),
        .SD_MISO    (SD_MISO),
        .SD_CS      (SD_CS),
        .SD_SCK     (SD_SCK),
        .SD_MOSI    (SD_MOSI),
        .sel        (sel),
        .sel_pending(sel_pending),
        .act        (act),
        .reset_img  (reset_img)
    );

    // Clock and cycle counter.
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            K_SEL:   return "sel";
            K_PEND:  return "sel_pending";
            K_RIMG:  return "reset_img";
            K_ACT:   return "act";
            K_CS:    return "SD_CS";
            K_VSS:   return "vsd_ss";
            K_MISO:  return "spi_miso";
            K_SCK:   return "SD_SCK_MOSI";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [7:0] actual(input int kind);
        case (kind)
            K_SEL:   return 8'(sel);
            K_PEND:  return 8'(sel_pending);
            K_RIMG:  return 8'(reset_img);
            K_ACT:   return 8'(act);
            K_CS:    return 8'(SD_CS);
            K_VSS:   return 8'(vsd_ss);
            K_MISO:  return 8'(spi_miso);
            K_SCK:   return 8'({SD_SCK, SD_MOSI});
            default: return 8'hff;
        endcase
    endfunction

    // Monitor: compares every queued expectation due in the current cycle.
    always @(negedge clk_sys) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_c   = exp_q.pop_front();
            mon_act = actual(mon_c.kind);
            checks++;
            if (mon_c.cyc != cyc || mon_act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", kname(mon_c.kind), cyc,
                         mon_act, mon_c.exp);
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk_sys);
        #1;
        img_mounted = '0;
        img_nz      = '0;
    endtask

    task automatic expect_v(input int kind, input logic [7:0] v);
        chk_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic mount(input logic [SLOTS-1:0] m, input logic [SLOTS-1:0] nz);
        img_mounted = m;
        img_nz      = nz;
    endtask

    initial begin
        // Reset values.
        repeat (3) step();
        reset = 1'b0;
        expect_v(K_SEL, 0); expect_v(K_PEND, 0); expect_v(K_RIMG, 0);
        expect_v(K_ACT, 0); expect_v(K_VSS, 8'h07); expect_v(K_CS, 1);
        step();
        spi_ss = 1'b0; spi_sck = 1'b1;
        expect_v(K_CS, 0); expect_v(K_SCK, 8'h2);
        step();
        spi_ss = 1'b1;
        expect_v(K_CS, 1); expect_v(K_SCK, 8'h0);

        // Mount slot 0 on an idle bus: sel=1 two cycles later.
        step();
        spi_sck = 1'b0;
        mount(3'b001, 3'b001);
        expect_v(K_SEL, 0); expect_v(K_PEND, 0);
        step();
        expect_v(K_PEND, 1); expect_v(K_SEL, 0); expect_v(K_RIMG, 1);
        step();
        expect_v(K_SEL, 1); expect_v(K_PEND, 0); expect_v(K_VSS, 8'h07); expect_v(K_CS, 1);
        step();
        spi_ss = 1'b0; spi_sck = 1'b1; vsd_miso = 3'b001;
        expect_v(K_VSS, 8'h06); expect_v(K_CS, 1); expect_v(K_SCK, 8'h0); expect_v(K_MISO, 1);
        step();
        spi_ss = 1'b1; spi_sck = 1'b0; vsd_miso = 3'b110; SD_MISO = 1'b1;
        expect_v(K_VSS, 8'h07); expect_v(K_MISO, 0);
        step();
        vsd_miso = '0; SD_MISO = 1'b0;

        // Mount slot 1 while the bus is busy for 50 cycles.
        step();
        spi_ss = 1'b0;
        mount(3'b010, 3'b010);
        expect_v(K_SEL, 1); expect_v(K_PEND, 0);
        for (int i = 1; i <= 50; i++) begin
            step();
            if (GUARD || i == 1) begin
                expect_v(K_PEND, 1); expect_v(K_SEL, 1);
                if (i < 50) expect_v(K_VSS, 8'h06);
            end else begin
                expect_v(K_PEND, 0); expect_v(K_SEL, 2);
                if (i < 50) expect_v(K_VSS, 8'h05);
            end
            if (i == 50) spi_ss = 1'b1;
        end
        step();
        expect_v(K_SEL, 2); expect_v(K_PEND, 0);

        // Same-cycle pulses on slots 1 and 0: slot 0 wins.
        step();
        mount(3'b011, 3'b011);
        step();
        expect_v(K_PEND, 1); expect_v(K_SEL, 2);
        step();
        expect_v(K_SEL, 1); expect_v(K_PEND, 0);

        // Unmount of the selected slot returns to the physical card.
        step();
        mount(3'b001, 3'b000);
        step();
        expect_v(K_PEND, 1); expect_v(K_SEL, 1);
        step();
        SD_MISO = 1'b1;
        expect_v(K_SEL, 0); expect_v(K_MISO, 1);
        step();
        SD_MISO = 1'b0;
        mount(3'b001, 3'b001);
        step();
        step();
        expect_v(K_SEL, 1);
        // Unmount of an unrelated slot is ignored.
        step();
        mount(3'b100, 3'b000);
        step();
        expect_v(K_PEND, 0); expect_v(K_SEL, 1);
        step();
        expect_v(K_PEND, 0); expect_v(K_SEL, 1);
        step();
        mount(3'b001, 3'b000);
        step();
        step();
        expect_v(K_SEL, 0);

        // Retriggered reset pulse: mounts at 10 and 60 -> high over 11..161.
        repeat (120) step();
        expect_v(K_RIMG, 0);
        for (int c = 0; c <= 165; c++) begin
            step();
            if (c == 10 || c == 60) mount(3'b100, 3'b000);
            expect_v(K_RIMG, (c >= 11 && c <= 161) ? 8'h1 : 8'h0);
            if (c == 12) expect_v(K_SEL, 0);
        end

        // One mosi toggle on the physical target: act[0] high for ACT_TIMEOUT cycles.
        for (int c = 0; c <= 24; c++) begin
            step();
            if (c == 0) spi_mosi = ~spi_mosi;
            expect_v(K_ACT, (c >= 2 && c <= 21) ? 8'h1 : 8'h0);
        end

        // Reset in the middle of an activity/reset pulse and a pending switch.
        step();
        spi_mosi = ~spi_mosi; spi_ss = 1'b0;
        mount(3'b001, 3'b001);
        step();
        expect_v(K_PEND, 1); expect_v(K_ACT, 0);
        step();
        expect_v(K_ACT, 1); expect_v(K_RIMG, 1);
        expect_v(K_PEND, GUARD ? 8'h1 : 8'h0); expect_v(K_SEL, GUARD ? 8'h0 : 8'h1);
        step();
        reset = 1'b1;
        expect_v(K_ACT, 0); expect_v(K_SEL, 0); expect_v(K_PEND, 0); expect_v(K_RIMG, 0);
        expect_v(K_VSS, 8'h07); expect_v(K_CS, 0);
        step();
        step();
        reset = 1'b0; spi_ss = 1'b1;
        expect_v(K_SEL, 0); expect_v(K_PEND, 0);
        step();
        step();
        expect_v(K_SEL, 0); expect_v(K_PEND, 0); expect_v(K_RIMG, 0); expect_v(K_ACT, 0);

        repeat (3) step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_route.md
# sd_route

Multi-slot SD card router for the core top level. Sits between the core's single SPI master and one physical SD socket plus `SLOTS` virtual SD cards backed by mounted images. Routes chip-select, clock and data to exactly one target. Switches target on image mount, only while the bus is idle. Also generates per-target activity flags for the LEDs and a retriggerable core reset pulse on mount.

## Interface
Parameters:
- `SLOTS`, 1: number of virtual card slots, legal range 1..4.
- `ACT_TIMEOUT`, 1000000: clk_sys cycles an activity flag stays high after the last SPI toggle.
- `RST_HOLD`, 10000000: clk_sys cycles `reset_img` stays high after a mount.
- `SEL_W`, $clog2(SLOTS+1): derived width of `sel`; not to be overridden.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `img_mounted`  in  SLOTS  one-cycle mount/unmount pulse per slot.
- `img_nz`  in  SLOTS  level; image size non-zero for the slot; sampled with `img_mounted`.
- `spi_ss`  in  1  core chip select, active low.
- `spi_sck`  in  1  core SPI clock.
- `spi_mosi`  in  1  core SPI data out.
- `spi_miso`  out  1  routed data back to core.
- `vsd_miso`  in  SLOTS  virtual card data.
- `vsd_ss`  out  SLOTS  per-slot virtual chip select, active low.
- `SD_MISO`  in  1  physical card data.
- `SD_CS`  out  1  physical chip select, active low.
- `SD_SCK`  out  1  physical clock, gated low when `SD_CS` is high.
- `SD_MOSI`  out  1  physical data, gated low when `SD_CS` is high.
- `sel`  out  SEL_W  active target: 0 = physical, k = slot k-1.
- `sel_pending`  out  1  a switch request is waiting for bus idle.
- `act`  out  SLOTS+1  activity per target; bit 0 = physical.
- `reset_img`  out  1  core cold-reset request.

## Operation
- Target decode:
  - When `sel`=0, `SD_CS`=`spi_ss` and all `vsd_ss` bits are 1.
  - When `sel`=k, `vsd_ss[k-1]`=`spi_ss` and `SD_CS`=1.
  - `spi_miso` muxes the selected target's data.
  - All decode is combinational from registered `sel`.
- Mount handling:
  - On `img_mounted[i]` with `img_nz[i]`=1, request target i+1.
  - On `img_mounted[i]` with `img_nz[i]`=0, request target 0, but only if the current or pending target is i+1; otherwise no request.
  - Simultaneous pulses: the lowest index wins.
- Switch FSM:
  - States IDLE and PENDING.
  - A request moves the FSM to PENDING and latches `req`.
  - In PENDING, when `spi_ss` is sampled 1, `sel`<=`req` and the FSM returns to IDLE.
  - A new request arriving while in PENDING overwrites `req`.
  - A request equal to the current `sel` is still accepted; it causes a harmless reload.
- Reset pulse:
  - Any `img_mounted` bit loads the hold counter with `RST_HOLD` and sets `reset_img`=1.
  - The counter decrements each cycle; `reset_img` drops the cycle it reads 0.
  - A mount during the hold reloads the counter, so the pulse is retriggerable.
- Activity:
  - One counter per target, saturating at `ACT_TIMEOUT`.
  - A selected target's counter clears on any toggle of `spi_mosi` or of its own miso, detected against a one-cycle delayed copy.
  - `act[t]`=counter<`ACT_TIMEOUT`.
  - Unselected targets keep counting up to saturation.
- Reset values: `sel`=0, FSM=IDLE, `sel_pending`=0, `reset_img`=0, every activity counter=`ACT_TIMEOUT` so `act`=0, edge-detect flops=0.
- Reset during PENDING discards the request; `sel` returns to 0.

## Timing
- `sel` changes one cycle after the first clock edge in PENDING on which `spi_ss`=1.
- When the bus is already idle, the mount pulse at cycle n gives `sel` valid at n+2 (n+1: PENDING, n+2: switched).
- `sel_pending` is high exactly during PENDING.
- `reset_img` rises at n+1 after the mount pulse at n, and stays high for `RST_HOLD`+1 cycles if not retriggered.
- An activity edge at cycle n causes `act` to rise at n+2: delay flop, then counter clear.

## Configuration
- `SD_ROUTE_GUARD_EN` defined: switch only on bus idle, as described above.
- `SD_ROUTE_GUARD_EN` undefined: the PENDING state still exists but exits unconditionally on its first cycle, ignoring `spi_ss`. Latency is identical when the bus is idle.

## Structure
- `sd_route_pkg` holds:
  - the state enum `sd_route_state_e`;
  - the `SD_ROUTE_MAX_SLOTS`=4 constant;
  - the `sel_w(slots)` function.
- Sub-module `sd_act_timer`: one saturating activity counter with its edge detect and flag output. It is instantiated SLOTS+1 times with a generate loop.

## Test plan
- Reset, then mount slot 0 with `img_nz`=1 and `spi_ss`=1 → `sel`=1 two cycles later; `vsd_ss[0]` follows `spi_ss`; `SD_CS`=1.
- Mount slot 1 while `spi_ss`=0 for 50 cycles → `sel_pending`=1 and `sel` unchanged throughout; `spi_ss` rises → `sel`=2 the next cycle.
- Same-cycle pulses on slots 1 and 0 → `sel`=1 (lowest index wins).
- Unmount pulse (`img_nz`=0) on slot 0 while `sel`=1 → `sel`=0; the same unmount on slot 2 while `sel`=1 → no change.
- With `RST_HOLD`=100, mount at cycle 10 and again at cycle 60 → `reset_img` high from cycle 11 through 161.
- With `ACT_TIMEOUT`=20, toggle `spi_mosi` once while `sel`=0 → `act[0]` high for 20 cycles and `act[1]` stays 0. Assert `reset` mid-pulse → all outputs return to their reset values immediately.
